// File: rtl/vc_rx_buffer.sv
// vc_rx_buffer: downstream end of a router-to-router link.
// Incoming flits are steered into per-VC circular FIFOs by vc_id. The head flit
// of every VC is presented to the local pipeline. Registered on/off flow control
// and VC-allocatability are returned upstream.
//
// Handshake: a flit transfers on a rising clk edge when is_valid=1. The buffer
// never stalls the link; upstream must honour is_on_off. A flit that arrives at a
// full VC, or that carries an illegal label, is dropped and flagged. pop[v]
// consumes head_flit[v] on the same edge and is ignored while head_valid[v]=0.

package noc_params;
    localparam int VC_NUM    = 4;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PAYLOAD_W = 16;

    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;

    typedef struct packed {
        flit_label_t            flit_label;
        logic [VC_SIZE-1:0]     vc_id;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;
endpackage

module vc_rx_buffer #(
    parameter int VC_NUM      = noc_params::VC_NUM,
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_SLACK   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  noc_params::flit_t   data,
    input  logic                is_valid,
    output logic [VC_NUM-1:0]   is_on_off,
    output logic [VC_NUM-1:0]   is_allocatable,
    output noc_params::flit_t   head_flit [VC_NUM],
    output logic [VC_NUM-1:0]   head_valid,
    input  logic [VC_NUM-1:0]   pop,
    output logic                overflow_err,
    output logic                protocol_err,
    output logic [VC_NUM-1:0]   o_dbg_busy
);
    import noc_params::*;

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} vc_state_t;

    flit_t              r_mem    [VC_NUM][BUFFER_SIZE];
    logic [PTR_W-1:0]   r_wr_ptr [VC_NUM];
    logic [PTR_W-1:0]   r_rd_ptr [VC_NUM];
    logic [CNT_W-1:0]   r_count  [VC_NUM];
    vc_state_t          r_state  [VC_NUM];
    logic [VC_NUM-1:0]  r_on_off;
    logic [VC_NUM-1:0]  r_alloc;
    logic               r_ovf_err;
    logic               r_prot_err;

    vc_state_t          w_state_next [VC_NUM];
    logic [CNT_W-1:0]   w_count_next [VC_NUM];
    logic [VC_NUM-1:0]  w_hit;
    logic [VC_NUM-1:0]  w_legal;
    logic [VC_NUM-1:0]  w_full;
    logic [VC_NUM-1:0]  w_wr;
    logic [VC_NUM-1:0]  w_pop;
    logic [VC_NUM-1:0]  w_tail_pop;
    logic [VC_NUM-1:0]  w_ovf;
    logic [VC_NUM-1:0]  w_prot;
    logic               w_in_head;

    // Per-VC write/pop decode: legality against VC state, then room check.
    always_comb begin
        w_in_head    = (data.flit_label == HEAD) || (data.flit_label == HEADTAIL);
        w_hit        = '0;
        w_legal      = '0;
        w_full       = '0;
        w_wr         = '0;
        w_pop        = '0;
        w_tail_pop   = '0;
        w_ovf        = '0;
        w_prot       = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_count_next[v] = r_count[v];
        end
        for (int v = 0; v < VC_NUM; v++) begin
            w_pop[v]      = pop[v] && (r_count[v] != '0);
            w_tail_pop[v] = w_pop[v] &&
                            ((r_mem[v][r_rd_ptr[v]].flit_label == TAIL) ||
                             (r_mem[v][r_rd_ptr[v]].flit_label == HEADTAIL));
            w_hit[v]      = is_valid && (int'(data.vc_id) == v);
            // A new head is only legal on a busy VC when its old tail leaves now.
            w_legal[v]    = (r_state[v] == IDLE) ? w_in_head : (!w_in_head || w_tail_pop[v]);
            w_full[v]     = (r_count[v] == CNT_W'(BUFFER_SIZE));
            w_prot[v]     = w_hit[v] && !w_legal[v];
            w_ovf[v]      = w_hit[v] && w_legal[v] && w_full[v] && !w_pop[v];
            w_wr[v]       = w_hit[v] && w_legal[v] && (!w_full[v] || w_pop[v]);
            w_count_next[v] = r_count[v] + CNT_W'(w_wr[v]) - CNT_W'(w_pop[v]);
        end
    end

    // VC FSM next state: an accepted head always wins over a same-cycle tail pop.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            w_state_next[v] = r_state[v];
            if (w_wr[v] && w_in_head) begin
                w_state_next[v] = BUSY;
            end else if ((r_state[v] == BUSY) && w_tail_pop[v]) begin
                w_state_next[v] = IDLE;
            end
        end
    end

    // Pointers, counts, FSM state, registered flow control and sticky errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
                r_state[v]  <= IDLE;
            end
            r_on_off   <= '1;
            r_alloc    <= '1;
            r_ovf_err  <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_wr[v]) begin
                    r_wr_ptr[v] <= r_wr_ptr[v] + PTR_W'(1);
                end
                if (w_pop[v]) begin
                    r_rd_ptr[v] <= r_rd_ptr[v] + PTR_W'(1);
                end
                r_count[v]  <= w_count_next[v];
                r_state[v]  <= w_state_next[v];
                r_on_off[v] <= (w_count_next[v] < CNT_W'(BUFFER_SIZE - OFF_SLACK));
                r_alloc[v]  <= (w_state_next[v] == IDLE);
            end
            if (|w_ovf) begin
                r_ovf_err <= 1'b1;
            end
            if (|w_prot) begin
                r_prot_err <= 1'b1;
            end
        end
    end

    // Flit storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (w_wr[v]) begin
                r_mem[v][r_wr_ptr[v]] <= data;
            end
        end
    end

    // Head presentation straight from storage; no write-through bypass.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            head_flit[v]  = r_mem[v][r_rd_ptr[v]];
            head_valid[v] = (r_count[v] != '0);
            o_dbg_busy[v] = (r_state[v] == BUSY);
        end
    end

    assign is_on_off      = r_on_off;
    assign is_allocatable = r_alloc;
    assign overflow_err   = r_ovf_err;
    assign protocol_err   = r_prot_err;

endmodule

// File: tb/tb_vc_rx_buffer.sv
// Testbench for vc_rx_buffer: directed link scenarios followed by randomized
// interleaved packet traffic on VC0/VC1, checked against a queue-based model.
module tb_vc_rx_buffer;
    import noc_params::*;

    localparam int VC_N  = noc_params::VC_NUM;
    localparam int SIZE  = 8;
    localparam int SLACK = 2;
    localparam int FW    = $bits(flit_t);

    // ---------------- clock / reset ----------------
    logic              clk;
    logic              rst;
    flit_t             data;
    logic              is_valid;
    logic [VC_N-1:0]   is_on_off;
    logic [VC_N-1:0]   is_allocatable;
    flit_t             head_flit [VC_N];
    logic [VC_N-1:0]   head_valid;
    logic [VC_N-1:0]   pop;
    logic              overflow_err;
    logic              protocol_err;
    logic [VC_N-1:0]   o_dbg_busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vc_rx_buffer #(
        .VC_NUM      (VC_N),
        .BUFFER_SIZE (SIZE),
        .OFF_SLACK   (SLACK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data           (data),
        .is_valid       (is_valid),
        .is_on_off      (is_on_off),
        .is_allocatable (is_allocatable),
        .head_flit      (head_flit),
        .head_valid     (head_valid),
        .pop            (pop),
        .overflow_err   (overflow_err),
        .protocol_err   (protocol_err),
        .o_dbg_busy     (o_dbg_busy)
    );

    // ---------------- scoreboard / counters ----------------
    logic [FW-1:0] exp_q [VC_N][$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    flit_t mdl_q [VC_N][$];
    logic  mdl_busy [VC_N];
    logic  mdl_ovf;
    logic  mdl_prot;

    function automatic logic is_head(input flit_label_t l);
        return (l == HEAD) || (l == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t l);
        return (l == TAIL) || (l == HEADTAIL);
    endfunction

    task automatic mdl_reset();
        for (int v = 0; v < VC_N; v++) begin
            mdl_q[v].delete();
            exp_q[v].delete();
            mdl_busy[v] = 1'b0;
        end
        mdl_ovf  = 1'b0;
        mdl_prot = 1'b0;
    endtask

    // One link cycle as the specification describes it: pops, then the write.
    task automatic mdl_apply(input logic v_in, input flit_t f, input logic [VC_N-1:0] p);
        int    pre_size [VC_N];
        logic  popping  [VC_N];
        logic  tailpop  [VC_N];
        logic  accepted [VC_N];
        int    w;
        logic  legal;
        for (int v = 0; v < VC_N; v++) begin
            pre_size[v] = mdl_q[v].size();
            popping[v]  = p[v] && (pre_size[v] > 0);
            tailpop[v]  = popping[v] && is_tail(mdl_q[v][0].flit_label);
            accepted[v] = 1'b0;
            if (popping[v]) void'(mdl_q[v].pop_front());
        end
        if (v_in && (int'(f.vc_id) < VC_N)) begin
            w = int'(f.vc_id);
            legal = mdl_busy[w] ? (!is_head(f.flit_label) || tailpop[w]) : is_head(f.flit_label);
            if (!legal) mdl_prot = 1'b1;
            else if ((pre_size[w] == SIZE) && !popping[w]) mdl_ovf = 1'b1;
            else begin
                accepted[w] = 1'b1;
                mdl_q[w].push_back(f);
                exp_q[w].push_back(FW'(f));
            end
        end
        for (int v = 0; v < VC_N; v++) begin
            if (accepted[v] && is_head(f.flit_label)) mdl_busy[v] = 1'b1;
            else if (tailpop[v]) mdl_busy[v] = 1'b0;
        end
    endtask

    task automatic check_status();
        logic [VC_N-1:0] e_hv, e_oo, e_al;
        for (int v = 0; v < VC_N; v++) begin
            e_hv[v] = mdl_q[v].size() > 0;
            e_oo[v] = (SIZE - mdl_q[v].size()) > SLACK;
            e_al[v] = !mdl_busy[v];
        end
        check("head_valid", 64'(head_valid), 64'(e_hv));
        check("is_on_off", 64'(is_on_off), 64'(e_oo));
        check("is_allocatable", 64'(is_allocatable), 64'(e_al));
        check("overflow_err", 64'(overflow_err), 64'(mdl_ovf));
        check("protocol_err", 64'(protocol_err), 64'(mdl_prot));
    endtask

    // ---------------- driver tasks ----------------
    function automatic flit_t mk(input flit_label_t l, input int vc);
        flit_t f;
        f.flit_label = l;
        f.vc_id      = VC_SIZE'(vc);
        f.payload    = PAYLOAD_W'($urandom);
        return f;
    endfunction

    task automatic step(input logic v_in, input flit_t f, input logic [VC_N-1:0] p);
        is_valid = v_in;
        data     = f;
        pop      = p;
        mdl_apply(v_in, f, p);
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic idle(input logic [VC_N-1:0] p);
        step(1'b0, '0, p);
    endtask

    task automatic do_reset();
        is_valid = 1'b0;
        pop      = '0;
        data     = '0;
        rst      = 1'b0;
        mdl_reset();
        #1;
        check_status();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int v = 0; v < VC_N; v++) begin
            if (rst && pop[v] && head_valid[v]) begin
                if (exp_q[v].size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_pop vc%0d: got head %0h expected no flit", v, head_flit[v]);
                end else begin
                    check($sformatf("head_flit vc%0d", v), 64'(head_flit[v]), 64'(exp_q[v].pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int sent [2];
    int rem  [2];
    int cyc;
    logic any_left;

    initial begin
        rst = 1'b0;
        is_valid = 1'b0;
        pop = '0;
        data = '0;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        check_status();
        rst = 1'b1;
        repeat (5) idle('0);

        // Single-flit packet on VC0.
        step(1'b1, mk(HEADTAIL, 0), '0);
        check("vc0_alloc_low", 64'(is_allocatable[0]), 64'd0);
        idle('0);
        idle(4'b0001);
        check("vc0_hv_after_pop", 64'(head_valid[0]), 64'd0);
        check("vc0_alloc_high", 64'(is_allocatable[0]), 64'd1);

        // HEAD + 5 BODY on VC1: on/off drops once six slots are used.
        step(1'b1, mk(HEAD, 1), '0);
        for (int i = 0; i < 4; i++) step(1'b1, mk(BODY, 1), '0);
        check("vc1_onoff_5", 64'(is_on_off[1]), 64'd1);
        step(1'b1, mk(BODY, 1), '0);
        check("vc1_onoff_6", 64'(is_on_off[1]), 64'd0);
        idle(4'b0010);
        check("vc1_onoff_pop", 64'(is_on_off[1]), 64'd1);

        // Fill VC1 to 8, then overflow, then write-with-pop while full.
        for (int i = 0; i < 3; i++) step(1'b1, mk(BODY, 1), '0);
        step(1'b1, mk(BODY, 1), '0);
        check("ovf_set", 64'(overflow_err), 64'd1);
        step(1'b1, mk(BODY, 1), 4'b0010);
        check("full_wr_pop_hv", 64'(head_valid[1]), 64'd1);

        // Protocol violations: BODY to idle VC2, HEAD to busy VC1.
        step(1'b1, mk(BODY, 2), '0);
        check("prot_set", 64'(protocol_err), 64'd1);
        check("vc2_empty", 64'(head_valid[2]), 64'd0);
        step(1'b1, mk(HEAD, 1), '0);

        // Close the VC1 packet and drain it.
        step(1'b1, mk(TAIL, 1), 4'b0010);
        for (int i = 0; i < SIZE; i++) idle(4'b0010);
        check("vc1_alloc_after_tail", 64'(is_allocatable[1]), 64'd1);

        // Reset in the middle of a packet.
        step(1'b1, mk(HEAD, 1), '0);
        step(1'b1, mk(BODY, 1), '0);
        do_reset();
        idle('0);

        // Randomized interleaved packets on VC0 and VC1.
        sent[0] = 0; sent[1] = 0; rem[0] = 0; rem[1] = 0;
        cyc = 0;
        while (((sent[0] < 20) || (sent[1] < 20)) && (cyc < 4000)) begin
            int vc;
            int len;
            logic go;
            flit_label_t lbl;
            logic [VC_N-1:0] p;
            vc  = $urandom_range(0, 1);
            p   = VC_N'($urandom_range(0, (1 << VC_N) - 1));
            go  = 1'b0;
            lbl = BODY;
            len = 0;
            if ((sent[vc] < 20) && (mdl_q[vc].size() < SIZE)) begin
                if (rem[vc] == 0) begin
                    if (!mdl_busy[vc]) begin
                        len = $urandom_range(1, 4);
                        if (len > 20 - sent[vc]) len = 20 - sent[vc];
                        lbl = (len == 1) ? HEADTAIL : HEAD;
                        go  = 1'b1;
                    end
                end else begin
                    lbl = (rem[vc] == 1) ? TAIL : BODY;
                    go  = 1'b1;
                end
            end
            if (go) begin
                step(1'b1, mk(lbl, vc), p);
                if (is_head(lbl)) rem[vc] = len - 1;
                else rem[vc] = rem[vc] - 1;
                sent[vc]++;
            end else begin
                idle(p);
            end
            cyc++;
        end
        if (cyc >= 4000) begin
            n_checks++;
            $display("FAIL random_timeout: got %0d/%0d flits sent expected 20/20", sent[0], sent[1]);
        end

        // Drain whatever remains.
        cyc = 0;
        any_left = 1'b1;
        while (any_left && (cyc < 100)) begin
            idle('1);
            any_left = 1'b0;
            for (int v = 0; v < VC_N; v++) if (mdl_q[v].size() > 0) any_left = 1'b1;
            cyc++;
        end
        if (any_left) begin
            n_checks++;
            $display("FAIL drain_timeout: got model not empty expected empty");
        end
        check("final_prot", 64'(protocol_err), 64'd0);
        check("final_ovf", 64'(overflow_err), 64'd0);
        repeat (2) idle('0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
